// File: rtl/cpu_clock_seq.sv
// Run/halt/step/burst sequencer: divides clk_50 into clk_t/clk_2t and issues whole CPU cycles on request.
// Optional macro STEP_DEBOUNCE_EN adds a DEBOUNCE-cycle stable-high filter on the step button.
module cpu_clock_seq #(
    parameter int CYCLE    = 2,
    parameter int BURST_W  = 8,
    parameter int DEBOUNCE = 16
) (
    input  logic               clk_50,
    input  logic               resetn,
    input  logic               run_req,
    input  logic               step_req,
    input  logic               burst_start,
    input  logic [BURST_W-1:0] burst_len,
    output logic               clk_t,
    output logic               clk_2t,
    output logic               cpu_en,
    output logic               busy,
    output logic [31:0]        cyc_count,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    localparam int HALF  = CYCLE / 2;
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

    if (CYCLE < 2 || (CYCLE % 2) != 0 || DEBOUNCE < 1) begin : g_bad_params
        $error("cpu_clock_seq: CYCLE must be even and >= 2, DEBOUNCE >= 1");
    end

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [BURST_W-1:0] remaining;
    logic               step_s1;
    logic               step_s2;
    logic               step_pulse;
    logic               rise_ok;
    logic               at_last;
    logic               rise;
    logic               fall;

    // Step button: two-flop synchronizer followed by a registered one-shot.
`ifdef STEP_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEBOUNCE + 2);
    localparam logic [DEB_W-1:0] DEB_FIRE = DEB_W'(DEBOUNCE);

    logic [DEB_W-1:0] deb_cnt;

    // Counter saturates one past DEB_FIRE so each high period fires exactly once.
    always_ff @(posedge clk_50 or negedge resetn) begin
        if (!resetn) begin
            step_s1    <= 1'b0;
            step_s2    <= 1'b0;
            deb_cnt    <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_s1 <= step_req;
            step_s2 <= step_s1;
            if (!step_s2) begin
                deb_cnt <= '0;
            end else if (deb_cnt <= DEB_FIRE) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
            step_pulse <= step_s2 && (deb_cnt == DEB_FIRE);
        end
    end
`else
    logic step_d;

    always_ff @(posedge clk_50 or negedge resetn) begin
        if (!resetn) begin
            step_s1    <= 1'b0;
            step_s2    <= 1'b0;
            step_d     <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            step_s1    <= step_req;
            step_s2    <= step_s1;
            step_d     <= step_s2;
            step_pulse <= step_s2 & ~step_d;
        end
    end
`endif

    // In STEP clk_t is low only before the single rise, so no extra "done" flag is needed.
    always_comb begin
        rise_ok = 1'b0;
        case (state)
            ST_RUN:   rise_ok = run_req;
            ST_STEP:  rise_ok = 1'b1;
            ST_BURST: rise_ok = (remaining != '0);
            default:  rise_ok = 1'b0;
        endcase
        at_last = (cnt == CNT_LAST);
        rise    = ~clk_t & rise_ok & at_last;
        fall    = clk_t & at_last;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!clk_t) begin
                    if (run_req) begin
                        state_nxt = ST_RUN;
                    end else if (burst_start && (burst_len != '0)) begin
                        state_nxt = ST_BURST;
                    end else if (step_pulse) begin
                        state_nxt = ST_STEP;
                    end
                end
            end
            ST_RUN: begin
                if (!run_req && !clk_t) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (fall) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_BURST: begin
                if ((remaining == '0) && !clk_t) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A high clk_t always keeps the divider running, so a started cycle always completes.
    always_ff @(posedge clk_50 or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            clk_t <= 1'b0;
        end else if (clk_t || rise_ok) begin
            if (at_last) begin
                cnt   <= '0;
                clk_t <= ~clk_t;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk_50 or negedge resetn) begin
        if (!resetn) begin
            clk_2t    <= 1'b0;
            cpu_en    <= 1'b0;
            cyc_count <= '0;
        end else begin
            cpu_en <= rise;
            if (rise) begin
                clk_2t    <= ~clk_2t;
                cyc_count <= cyc_count + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge resetn) begin
        if (!resetn) begin
            remaining <= '0;
        end else if ((state == ST_IDLE) && (state_nxt == ST_BURST)) begin
            remaining <= burst_len;
        end else if ((state == ST_BURST) && rise) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign busy      = (state != ST_IDLE) | clk_t;
    assign state_dbg = state;

endmodule

// File: tb/tb_cpu_clock_seq.sv
// Directed bench for cpu_clock_seq: one instance with CYCLE=2 and one with CYCLE=4 share the same inputs.
module tb_cpu_clock_seq;

    logic        clk_50      = 1'b0;
    logic        resetn      = 1'b0;
    logic        run_req     = 1'b0;
    logic        step_req    = 1'b0;
    logic        burst_start = 1'b0;
    logic [7:0]  burst_len   = 8'd0;

    logic        clk_t2, clk_2t2, cpu_en2, busy2;
    logic [31:0] cyc_count2;
    logic [1:0]  state_dbg2;
    logic        clk_t4, clk_2t4, cpu_en4, busy4;
    logic [31:0] cyc_count4;
    logic [1:0]  state_dbg4;

    int checks = 0;
    int errors = 0;
    int cyc_num = 0;

    int en_cnt2 = 0, rise_cnt2 = 0, en_cnt4 = 0, rise_cnt4 = 0;
    int base_en2 = 0, base_rise2 = 0, base_en4 = 0, base_rise4 = 0, base_t4 = 0;
    logic prev2 = 1'b0, prev4 = 1'b0;
    int rise_t4[$];
    logic [31:0] exp_q[$];

    cpu_clock_seq #(.CYCLE(2), .BURST_W(8), .DEBOUNCE(16)) dut2 (
        .clk_50(clk_50), .resetn(resetn), .run_req(run_req), .step_req(step_req),
        .burst_start(burst_start), .burst_len(burst_len), .clk_t(clk_t2), .clk_2t(clk_2t2),
        .cpu_en(cpu_en2), .busy(busy2), .cyc_count(cyc_count2), .state_dbg(state_dbg2)
    );

    cpu_clock_seq #(.CYCLE(4), .BURST_W(8), .DEBOUNCE(16)) dut4 (
        .clk_50(clk_50), .resetn(resetn), .run_req(run_req), .step_req(step_req),
        .burst_start(burst_start), .burst_len(burst_len), .clk_t(clk_t4), .clk_2t(clk_2t4),
        .cpu_en(cpu_en4), .busy(busy4), .cyc_count(cyc_count4), .state_dbg(state_dbg4)
    );

    always #5 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc_num <= cyc_num + 1;

    always @(negedge clk_50) begin
        if (cpu_en2) en_cnt2++;
        if (cpu_en4) en_cnt4++;
        if (clk_t2 && !prev2) rise_cnt2++;
        if (clk_t4 && !prev4) begin
            rise_cnt4++;
            rise_t4.push_back(cyc_num);
        end
        prev2 = clk_t2;
        prev4 = clk_t4;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic clear_counts();
        base_en2   = en_cnt2;
        base_rise2 = rise_cnt2;
        base_en4   = en_cnt4;
        base_rise4 = rise_cnt4;
        base_t4    = rise_t4.size();
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        run_req     = 1'b0;
        step_req    = 1'b0;
        burst_start = 1'b0;
        burst_len   = 8'd0;
        tick(2);
        resetn = 1'b1;
        tick(1);
        clear_counts();
    endtask

    task automatic test_reset();
        do_reset();
        tick(20);
        checks++; if ({clk_t2, clk_2t2, busy2} !== 3'b000) begin errors++; $display("FAIL reset_idle_c2: clk_t/clk_2t/busy got %b expected 000", {clk_t2, clk_2t2, busy2}); end
        checks++; if (cyc_count2 !== 32'd0) begin errors++; $display("FAIL reset_count_c2: got %0d expected 0", cyc_count2); end
        checks++; if ((en_cnt2 - base_en2) !== 0) begin errors++; $display("FAIL reset_en_c2: pulses %0d expected 0", en_cnt2 - base_en2); end
        checks++; if ({clk_t4, clk_2t4, busy4} !== 3'b000) begin errors++; $display("FAIL reset_idle_c4: clk_t/clk_2t/busy got %b expected 000", {clk_t4, clk_2t4, busy4}); end
        checks++; if (cyc_count4 !== 32'd0) begin errors++; $display("FAIL reset_count_c4: got %0d expected 0", cyc_count4); end
        checks++; if ((en_cnt4 - base_en4) !== 0) begin errors++; $display("FAIL reset_en_c4: pulses %0d expected 0", en_cnt4 - base_en4); end
    endtask

    task automatic test_step();
        do_reset();
        step_req = 1'b1;
        tick(4);
        checks++; if ({busy2, clk_t2} !== 2'b10) begin errors++; $display("FAIL step_enter: busy/clk_t got %b expected 10", {busy2, clk_t2}); end
        tick(1);
        checks++; if ({clk_t2, cpu_en2} !== 2'b11) begin errors++; $display("FAIL step_rise: clk_t/cpu_en got %b expected 11", {clk_t2, cpu_en2}); end
        tick(1);
        checks++; if ({clk_t2, busy2} !== 2'b00) begin errors++; $display("FAIL step_fall: clk_t/busy got %b expected 00", {clk_t2, busy2}); end
        tick(4);
        step_req = 1'b0;
        tick(10);
        checks++; if ((rise_cnt2 - base_rise2) !== 1) begin errors++; $display("FAIL step_rises: got %0d expected 1", rise_cnt2 - base_rise2); end
        checks++; if ((en_cnt2 - base_en2) !== 1) begin errors++; $display("FAIL step_en: got %0d expected 1", en_cnt2 - base_en2); end
        checks++; if ({clk_2t2, busy2} !== 2'b10) begin errors++; $display("FAIL step_final: clk_2t/busy got %b expected 10", {clk_2t2, busy2}); end
        checks++; if (cyc_count2 !== 32'd1) begin errors++; $display("FAIL step_count: got %0d expected 1", cyc_count2); end
    endtask

    task automatic test_burst();
        int t0;
        int got;
        do_reset();
        burst_len   = 8'd5;
        burst_start = 1'b1;
        t0 = cyc_num;
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(t0 + 3 + 4 * i));
        tick(1);
        burst_start = 1'b0;
        burst_len   = 8'd0;
        tick(3);
        step_req = 1'b1;
        tick(6);
        step_req = 1'b0;
        tick(20);
        checks++; if ((rise_t4.size() - base_t4) !== 5) begin errors++; $display("FAIL burst_rises: got %0d expected 5", rise_t4.size() - base_t4); end
        for (int i = 0; i < 5; i++) begin
            got = (base_t4 + i < rise_t4.size()) ? rise_t4[base_t4 + i] : -1;
            checks++; if (32'(got) !== exp_q[i]) begin errors++; $display("FAIL burst_rise_time[%0d]: cycle %0d expected %0d", i, got, exp_q[i]); end
        end
        checks++; if (cyc_count4 !== 32'd5) begin errors++; $display("FAIL burst_count: got %0d expected 5", cyc_count4); end
        checks++; if ((en_cnt4 - base_en4) !== 5) begin errors++; $display("FAIL burst_en: got %0d expected 5", en_cnt4 - base_en4); end
        checks++; if ({clk_2t4, clk_t4, busy4} !== 3'b100) begin errors++; $display("FAIL burst_final: clk_2t/clk_t/busy got %b expected 100", {clk_2t4, clk_t4, busy4}); end
    endtask

    task automatic test_run_drop();
        do_reset();
        run_req = 1'b1;
        tick(8);
        checks++; if (clk_t2 !== 1'b1) begin errors++; $display("FAIL run_high_at_drop: clk_t got %b expected 1", clk_t2); end
        run_req = 1'b0;
        tick(1);
        checks++; if ({clk_t2, busy2} !== 2'b01) begin errors++; $display("FAIL run_completes: clk_t/busy got %b expected 01", {clk_t2, busy2}); end
        tick(9);
        checks++; if ((rise_cnt2 - base_rise2) !== 4) begin errors++; $display("FAIL run_rises: got %0d expected 4", rise_cnt2 - base_rise2); end
        checks++; if ((en_cnt2 - base_en2) !== 4) begin errors++; $display("FAIL run_en: got %0d expected 4", en_cnt2 - base_en2); end
        checks++; if (cyc_count2 !== 32'd4) begin errors++; $display("FAIL run_count: got %0d expected 4", cyc_count2); end
        checks++; if ({state_dbg2, clk_t2, clk_2t2, busy2} !== 5'b00000) begin errors++; $display("FAIL run_final: state/clk_t/clk_2t/busy got %b expected 00000", {state_dbg2, clk_t2, clk_2t2, busy2}); end
    endtask

    task automatic test_zero_burst_priority();
        do_reset();
        burst_len   = 8'd0;
        burst_start = 1'b1;
        tick(1);
        checks++; if ({busy2, busy4} !== 2'b00) begin errors++; $display("FAIL zero_burst_busy: got %b expected 00", {busy2, busy4}); end
        burst_start = 1'b0;
        tick(5);
        checks++; if ((cyc_count2 | cyc_count4) !== 32'd0) begin errors++; $display("FAIL zero_burst_count: got %0d/%0d expected 0/0", cyc_count2, cyc_count4); end
        run_req     = 1'b1;
        burst_start = 1'b1;
        burst_len   = 8'd3;
        step_req    = 1'b1;
        tick(1);
        checks++; if ({state_dbg2, state_dbg4} !== 4'b0101) begin errors++; $display("FAIL prio_state: got %b expected 0101", {state_dbg2, state_dbg4}); end
        burst_start = 1'b0;
        burst_len   = 8'd0;
        tick(5);
        checks++; if (state_dbg2 !== 2'd1) begin errors++; $display("FAIL prio_stays_run: got %0d expected 1", state_dbg2); end
        run_req  = 1'b0;
        step_req = 1'b0;
        tick(10);
        checks++; if ({state_dbg2, busy2} !== 3'b000) begin errors++; $display("FAIL prio_idle: state/busy got %b expected 000", {state_dbg2, busy2}); end
        checks++; if (cyc_count2 !== 32'd3) begin errors++; $display("FAIL prio_count_c2: got %0d expected 3", cyc_count2); end
        checks++; if (cyc_count4 !== 32'd1) begin errors++; $display("FAIL prio_count_c4: got %0d expected 1", cyc_count4); end
    endtask

    task automatic test_run_after_burst();
        do_reset();
        burst_len   = 8'd2;
        burst_start = 1'b1;
        tick(1);
        burst_start = 1'b0;
        burst_len   = 8'd0;
        tick(1);
        run_req = 1'b1;
        tick(3);
        checks++; if (state_dbg4 !== 2'd3) begin errors++; $display("FAIL rab_in_burst: got %0d expected 3", state_dbg4); end
        tick(11);
        checks++; if (state_dbg4 !== 2'd1) begin errors++; $display("FAIL rab_enters_run: got %0d expected 1", state_dbg4); end
        run_req = 1'b0;
        tick(10);
        checks++; if (state_dbg4 !== 2'd0) begin errors++; $display("FAIL rab_idle: got %0d expected 0", state_dbg4); end
        checks++; if (cyc_count4 !== 32'd3) begin errors++; $display("FAIL rab_count: got %0d expected 3", cyc_count4); end
        checks++; if ((en_cnt4 - base_en4) !== 3) begin errors++; $display("FAIL rab_en: got %0d expected 3", en_cnt4 - base_en4); end
        checks++; if (clk_2t4 !== 1'b1) begin errors++; $display("FAIL rab_clk_2t: got %b expected 1", clk_2t4); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        burst_len   = 8'd5;
        burst_start = 1'b1;
        tick(1);
        burst_start = 1'b0;
        burst_len   = 8'd0;
        tick(2);
        checks++; if ({clk_t4, cpu_en4} !== 2'b11) begin errors++; $display("FAIL rst_mid_pre: clk_t/cpu_en got %b expected 11", {clk_t4, cpu_en4}); end
        resetn = 1'b0;
        #1;
        checks++; if ({clk_t4, clk_2t4, cpu_en4, busy4} !== 4'b0000) begin errors++; $display("FAIL rst_mid_outputs: clk_t/clk_2t/cpu_en/busy got %b expected 0000", {clk_t4, clk_2t4, cpu_en4, busy4}); end
        checks++; if ({state_dbg4, cyc_count4} !== 34'd0) begin errors++; $display("FAIL rst_mid_state: state %0d count %0d expected 0 0", state_dbg4, cyc_count4); end
        tick(2);
        resetn = 1'b1;
        clear_counts();
        tick(20);
        checks++; if ((rise_cnt4 - base_rise4) !== 0) begin errors++; $display("FAIL rst_mid_no_cycles: rises %0d expected 0", rise_cnt4 - base_rise4); end
        checks++; if ({busy4, cyc_count4} !== 33'd0) begin errors++; $display("FAIL rst_mid_after: busy %b count %0d expected 0 0", busy4, cyc_count4); end
        checks++; if ((rise_cnt2 - base_rise2) !== 0) begin errors++; $display("FAIL rst_mid_no_cycles_c2: rises %0d expected 0", rise_cnt2 - base_rise2); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_burst();
        test_run_drop();
        test_zero_burst_priority();
        test_run_after_burst();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
